// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive bit timer.
// Optional stop-bit checking is enabled with the UART_RX_STOP_CHECK_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        DONE,
        BREAK
    } uart_state_e;

    localparam int FRAME_BITS = 11;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the raw rx pin plus falling-edge detect.
// Every flop resets to 1 so a reset never looks like a start edge on an idle line.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   rx_s_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff   <= '1;
            rx_s_prev <= 1'b1;
        end else begin
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], rx};
            rx_s_prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_ff[SYNC_STAGES-1];
    assign fall = rx_s_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_bit_timer.sv
// Baud timing and control for the UART receive shift register: start detect, bit-centre strobes, done.
// Define UART_RX_STOP_CHECK_EN to flag a low stop bit (frame_err) and wait out the break condition.
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int FRAME_BITS  = uart_pkg::FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic shift,
    output logic done,
    output logic busy,
    output logic false_start,
    output logic frame_err
);

    localparam int CPB    = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF   = CPB / 2;
    localparam int BAUD_W = $clog2(CPB);

    logic              rx_s;
    logic              fall;
    uart_state_e       state_q, state_n;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_n;
    logic [3:0]        bit_cnt_q, bit_cnt_n;
    logic              shift_n, done_n, false_start_n, frame_err_n;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    always_comb begin
        state_n       = state_q;
        baud_cnt_n    = baud_cnt_q;
        bit_cnt_n     = bit_cnt_q;
        shift_n       = 1'b0;
        done_n        = 1'b0;
        false_start_n = 1'b0;
        frame_err_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_n    = START;
                    baud_cnt_n = '0;
                    bit_cnt_n  = '0;
                end
            end
            // Half a bit after the edge the line must still be low, otherwise it was a glitch.
            START: begin
                if (baud_cnt_q == BAUD_W'(HALF - 1)) begin
                    baud_cnt_n = '0;
                    if (!rx_s) begin
                        shift_n   = 1'b1;
                        bit_cnt_n = 4'd1;
                        state_n   = DATA;
                    end else begin
                        false_start_n = 1'b1;
                        state_n       = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt_q == BAUD_W'(CPB - 1)) begin
                    shift_n    = 1'b1;
                    baud_cnt_n = '0;
                    bit_cnt_n  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q + 4'd1 == 4'(FRAME_BITS)) begin
                        state_n = DONE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt_q + BAUD_W'(1);
                end
            end
            DONE: begin
                done_n = 1'b1;
`ifdef UART_RX_STOP_CHECK_EN
                if (!rx_s) begin
                    frame_err_n = 1'b1;
                    state_n     = BREAK;
                end else begin
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            // A held-low line must go high again before the next start edge can count.
            BREAK: begin
`ifdef UART_RX_STOP_CHECK_EN
                if (rx_s) begin
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift       <= 1'b0;
            done        <= 1'b0;
            false_start <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_n;
            baud_cnt_q  <= baud_cnt_n;
            bit_cnt_q   <= bit_cnt_n;
            shift       <= shift_n;
            done        <= done_n;
            false_start <= false_start_n;
            frame_err   <= frame_err_n;
            busy        <= (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: randomized frames scored against a timing model of the line.
// Expectations for frame_err and break handling follow UART_RX_STOP_CHECK_EN when it is defined.
module tb_uart_rx_bit_timer;

    localparam int CLK_HZ = 50_000_000;
    localparam int SYNC   = 2;
    localparam int CPB    = CLK_HZ / 115200;
    localparam int LAT    = CPB / 2 + SYNC + 1;
    localparam int CPB_S  = CLK_HZ / 9600;
    localparam int LAT_S  = CPB_S / 2 + SYNC + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic shift, done, busy, false_start, frame_err;
    logic reset_s = 1'b1;
    logic rx_slow = 1'b1;
    logic shift_s, done_s, busy_s, false_start_s, frame_err_s;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic done_d = 1'b0;

    int shift_q[$], rxbit_q[$], done_q[$], fs_q[$], fe_q[$], bad_q[$], slow_q[$];
    int exp_shift[$], exp_bit[$], exp_done[$], exp_fs[$], exp_fe[$], exp_bad[$];

    uart_rx_bit_timer #(.CLK_HZ(CLK_HZ), .BAUD(115200), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .rx(rx), .shift(shift), .done(done),
        .busy(busy), .false_start(false_start), .frame_err(frame_err)
    );

    uart_rx_bit_timer #(.CLK_HZ(CLK_HZ), .BAUD(9600), .SYNC_STAGES(SYNC)) dut_slow (
        .clk(clk), .reset(reset_s), .rx(rx_slow), .shift(shift_s), .done(done_s),
        .busy(busy_s), .false_start(false_start_s), .frame_err(frame_err_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the index of the clock edge that produced it.
    always @(negedge clk) begin
        if (shift) begin
            shift_q.push_back(cyc);
            rxbit_q.push_back(int'(rx));
        end
        if (done)        done_q.push_back(cyc);
        if (false_start) fs_q.push_back(cyc);
        if (frame_err)   fe_q.push_back(cyc);
        if (done_d)      bad_q.push_back(int'(busy));
        if (shift_s)     slow_q.push_back(cyc);
        done_d = done;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearAll();
        shift_q.delete(); rxbit_q.delete(); done_q.delete(); fs_q.delete();
        fe_q.delete(); bad_q.delete();
        exp_shift.delete(); exp_bit.delete(); exp_done.delete(); exp_fs.delete();
        exp_fe.delete(); exp_bad.delete();
    endtask

    // Drives one frame starting now and queues the strobes an ideal receiver would produce.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input int stop_cycles, input int gap);
        logic [10:0] frame;
        logic        par;
        int          f, n;
        par   = 1'($urandom_range(0, 1));
        frame = {stop_bit, par, data, 1'b0};
        f     = cyc;
        for (int i = 0; i < 11; i++) begin
            exp_shift.push_back(f + LAT + i * CPB);
            exp_bit.push_back(int'(frame[i]));
        end
        exp_done.push_back(f + LAT + 10 * CPB + 1);
`ifdef UART_RX_STOP_CHECK_EN
        if (!stop_bit) begin
            exp_fe.push_back(f + LAT + 10 * CPB + 1);
            exp_bad.push_back(1);
        end else begin
            exp_bad.push_back(0);
        end
`else
        exp_bad.push_back(0);
`endif
        for (int i = 0; i < 11; i++) begin
            if (i == 1) checkOutput("busy_in_frame", int'(busy), 1);
            rx = frame[i];
            n  = (i == 10) ? stop_cycles : CPB;
            repeat (n) begin
                @(posedge clk); #1;
            end
        end
        if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic checkScenario(input string tag);
        repeat (600) @(posedge clk);
        #1;
        checkOutput({tag, "_shift_count"}, shift_q.size(), exp_shift.size());
        for (int i = 0; i < shift_q.size() && i < exp_shift.size(); i++) begin
            checkOutput({tag, "_shift_time"}, shift_q[i], exp_shift[i]);
            checkOutput({tag, "_shift_bit"}, rxbit_q[i], exp_bit[i]);
        end
        checkOutput({tag, "_done_count"}, done_q.size(), exp_done.size());
        for (int i = 0; i < done_q.size() && i < exp_done.size(); i++)
            checkOutput({tag, "_done_time"}, done_q[i], exp_done[i]);
        checkOutput({tag, "_fs_count"}, fs_q.size(), exp_fs.size());
        for (int i = 0; i < fs_q.size() && i < exp_fs.size(); i++)
            checkOutput({tag, "_fs_time"}, fs_q[i], exp_fs[i]);
        checkOutput({tag, "_fe_count"}, fe_q.size(), exp_fe.size());
        for (int i = 0; i < fe_q.size() && i < exp_fe.size(); i++)
            checkOutput({tag, "_fe_time"}, fe_q[i], exp_fe[i]);
        for (int i = 0; i < bad_q.size() && i < exp_bad.size(); i++)
            checkOutput({tag, "_busy_after_done"}, bad_q[i], exp_bad[i]);
        checkOutput({tag, "_busy_idle"}, int'(busy), 0);
    endtask

    initial begin
        logic [10:0] frame;
        int          f;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_shift", int'(shift), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_false_start", int'(false_start), 0);
        checkOutput("rst_frame_err", int'(frame_err), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end

        // 0x55 at the default rate
        clearAll();
        applyStimulus(8'h55, 1'b1, CPB, 20);
        checkScenario("frame55");

        // Short low glitch
        clearAll();
        f  = cyc;
        rx = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
        end
        rx = 1'b1;
        exp_fs.push_back(f + LAT);
        checkScenario("glitch");

        // Reset one cycle after the 5th shift, then a clean frame
        clearAll();
        frame = {1'b1, 1'b0, 8'hA3, 1'b0};
        for (int c = 0; c < 11 * CPB && shift_q.size() < 5; c++) begin
            rx = frame[c / CPB];
            @(posedge clk); #1;
        end
        checkOutput("abort_shift_count", shift_q.size(), 5);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_shift", int'(shift), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_false_start", int'(false_start), 0);
        checkOutput("abort_frame_err", int'(frame_err), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        clearAll();
        applyStimulus(8'($urandom), 1'b1, CPB, 10);
        checkScenario("after_reset");

        // Back-to-back frames with no idle gap
        clearAll();
        applyStimulus(8'($urandom), 1'b1, CPB, 0);
        applyStimulus(8'($urandom), 1'b1, CPB, 5);
        checkScenario("back2back");

        // Random data with random idle gaps
        clearAll();
        for (int k = 0; k < 2; k++)
            applyStimulus(8'($urandom), 1'b1, CPB, int'($urandom_range(1, 300)));
        checkScenario("random");

        // Stop bit held low for 2000 clocks
        clearAll();
        applyStimulus(8'($urandom), 1'b0, 1000, 0);
`ifdef UART_RX_STOP_CHECK_EN
        checkOutput("break_busy", int'(busy), 1);
`else
        checkOutput("break_busy", int'(busy), 0);
`endif
        repeat (1000) begin
            @(posedge clk); #1;
        end
        rx = 1'b1;
        checkScenario("stop_low");

        // 9600 baud instance: first shift after half a bit, then one bit apart
        reset_s = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        f       = cyc;
        rx_slow = 1'b0;
        for (int c = 0; c < LAT_S + CPB_S + 100 && slow_q.size() < 2; c++) begin
            @(posedge clk); #1;
        end
        checkOutput("slow_shift_count", slow_q.size(), 2);
        if (slow_q.size() >= 2) begin
            checkOutput("slow_first_shift", slow_q[0], f + LAT_S);
            checkOutput("slow_spacing", slow_q[1] - slow_q[0], CPB_S);
        end
        reset_s = 1'b1;
        rx_slow = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
